// File: rtl/result_signature_checker.sv
// Regression-harness result checker: drops a settle window of samples, folds the rest into
// a MISR signature and flags pass/fail against a golden value. Optional stall counter: RESULT_SIG_STALL_CNT_EN.
module result_signature_checker #(
    parameter int WIDTH      = 64,
    parameter int SETTLE_CYC = 10,
    parameter int TOTAL_CYC  = 99
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] expected,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [WIDTH-1:0] signature,
    output logic [31:0]      sample_cnt
`ifdef RESULT_SIG_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_ACCUM  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [31:0] L_SETTLE_CNT = 32'(SETTLE_CYC);
    localparam logic [31:0] L_TOTAL_CNT  = 32'(TOTAL_CYC);
    localparam logic [1:0]  L_RUN_STATE  = (SETTLE_CYC == 0) ? S_ACCUM : S_SETTLE;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sig;
    logic [WIDTH-1:0] r_expected;
    logic [31:0]      r_cnt;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_sig_nxt;
    logic [WIDTH-1:0] w_expected_nxt;
    logic [31:0]      w_cnt_nxt;
    logic [31:0]      w_cnt_inc;
    logic             w_accept;
    logic             w_fb;

    assign w_accept  = in_valid && !start && (r_state == S_SETTLE || r_state == S_ACCUM);
    assign w_cnt_inc = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;
    assign w_fb      = r_sig[WIDTH-1] ^ r_sig[2] ^ r_sig[0];

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_sig_nxt      = r_sig;
        w_expected_nxt = r_expected;
        w_cnt_nxt      = r_cnt;
        if (start) begin
            w_state_nxt = L_RUN_STATE;
            w_sig_nxt   = '0;
            w_cnt_nxt   = '0;
        end else if (w_accept) begin
            w_cnt_nxt = w_cnt_inc;
            if (r_state == S_SETTLE) begin
                if (w_cnt_inc == L_SETTLE_CNT) begin
                    w_state_nxt = S_ACCUM;
                end
            end else begin
                w_sig_nxt = in_data ^ {r_sig[WIDTH-2:0], w_fb};
                if (w_cnt_inc == L_TOTAL_CNT) begin
                    w_state_nxt    = S_DONE;
                    w_expected_nxt = expected;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state    <= S_IDLE;
            r_sig      <= '0;
            r_expected <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sig      <= w_sig_nxt;
            r_expected <= w_expected_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

`ifdef RESULT_SIG_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_stall_cnt <= '0;
        end else if (start) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_ACCUM && !in_valid && r_stall_cnt != 32'hFFFF_FFFF) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign busy       = (r_state == S_SETTLE) || (r_state == S_ACCUM);
    assign done       = (r_state == S_DONE);
    assign pass       = done && (r_sig == r_expected);
    assign fail       = done && (r_sig != r_expected);
    assign signature  = r_sig;
    assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_result_signature_checker.sv
// Directed bench for result_signature_checker: a short-run instance (TOTAL_CYC=12) driven from a
// vector table plus corner sequences, and a default-parameter instance for the DONE-hold run.
module tb_result_signature_checker;

    logic        clk = 1'b0;
    logic        reset_l;
    logic        start_a, start_b;
    logic        in_valid;
    logic [63:0] in_data;
    logic [63:0] expected;

    logic        busy_a, done_a, pass_a, fail_a;
    logic [63:0] sig_a;
    logic [31:0] cnt_a;
    logic        busy_b, done_b, pass_b, fail_b;
    logic [63:0] sig_b;
    logic [31:0] cnt_b;
`ifdef RESULT_SIG_STALL_CNT_EN
    logic [31:0] stall_a, stall_b;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    result_signature_checker #(.WIDTH(64), .SETTLE_CYC(10), .TOTAL_CYC(12)) dut_a (
        .clk(clk), .reset_l(reset_l), .start(start_a), .in_valid(in_valid),
        .in_data(in_data), .expected(expected), .busy(busy_a), .done(done_a),
        .pass(pass_a), .fail(fail_a), .signature(sig_a), .sample_cnt(cnt_a)
`ifdef RESULT_SIG_STALL_CNT_EN
        , .stall_cnt(stall_a)
`endif
    );

    result_signature_checker dut_b (
        .clk(clk), .reset_l(reset_l), .start(start_b), .in_valid(in_valid),
        .in_data(in_data), .expected(expected), .busy(busy_b), .done(done_b),
        .pass(pass_b), .fail(fail_b), .signature(sig_b), .sample_cnt(cnt_b)
`ifdef RESULT_SIG_STALL_CNT_EN
        , .stall_cnt(stall_b)
`endif
    );

    typedef struct {
        logic [63:0] data;
        bit          gap;
        logic [63:0] exp_in;
        logic [63:0] sig;
        bit          pass;
        logic [31:0] stall;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start pulse carries a valid sample that must be ignored.
    task automatic pulse_start_a();
        start_a  = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'hDEAD_BEEF_0000_FFFF;
        tick();
        start_a  = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic run_samples(input int n, input logic [63:0] d, input bit gap);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = d;
            tick();
            if (gap && i < n - 1) begin
                in_valid = 1'b0;
                in_data  = ~d;
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        // Hand-computed: data=1 -> sig 1 after sample 11, then fb=1 gives {..,1,1}^1 = 2.
        // data=MSB -> sig=MSB, fb=1 -> 1 ^ MSB. data=4 -> sig=4, fb=bit2=1 -> 9 ^ 4 = D.
        vecs[0] = '{64'h1, 1'b0, 64'h2, 64'h2, 1'b1, 32'd0};
        vecs[1] = '{64'h1, 1'b0, 64'h3, 64'h2, 1'b0, 32'd0};
        vecs[2] = '{64'h1, 1'b1, 64'h2, 64'h2, 1'b1, 32'd2};
        vecs[3] = '{64'h8000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0001,
                    64'h8000_0000_0000_0001, 1'b1, 32'd0};
        vecs[4] = '{64'h4, 1'b0, 64'h0, 64'hD, 1'b0, 32'd0};

        reset_l  = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        expected = '0;
        #12;
        check("reset_busy", 64'(busy_a), 64'd0);
        check("reset_done_pass_fail", {61'd0, done_a, pass_a, fail_a}, 64'd0);
        check("reset_sig", sig_a, 64'd0);
        check("reset_cnt", 64'(cnt_a), 64'd0);
        reset_l = 1'b1;
        tick();

        // Idle ignores samples.
        run_samples(3, 64'h5, 1'b0);
        check("idle_ignore_cnt", 64'(cnt_a), 64'd0);
        check("idle_busy", 64'(busy_a), 64'd0);

        // Scenario 1 with intermediate observation.
        expected = 64'h2;
        pulse_start_a();
        check("s1_start_cnt", 64'(cnt_a), 64'd0);
        check("s1_busy", 64'(busy_a), 64'd1);
        run_samples(10, 64'h1, 1'b0);
        check("s1_settle_sig", sig_a, 64'd0);
        check("s1_settle_cnt", 64'(cnt_a), 64'd10);
        run_samples(1, 64'h1, 1'b0);
        check("s1_sample11_sig", sig_a, 64'd1);
        check("s1_sample11_done", 64'(done_a), 64'd0);
        run_samples(1, 64'h1, 1'b0);
        check("s1_done", {62'd0, done_a, busy_a}, 64'b10);
        check("s1_pass_fail", {62'd0, pass_a, fail_a}, 64'b10);
        check("s1_sig", sig_a, 64'h2);

        // Table of complete runs.
        for (int v = 0; v < 5; v++) begin
            expected = vecs[v].exp_in;
            pulse_start_a();
            run_samples(12, vecs[v].data, vecs[v].gap);
            check($sformatf("vec%0d_sig", v), sig_a, vecs[v].sig);
            check($sformatf("vec%0d_pass_fail", v), {61'd0, done_a, pass_a, fail_a},
                  {61'd0, 1'b1, vecs[v].pass, !vecs[v].pass});
            check($sformatf("vec%0d_cnt", v), 64'(cnt_a), 64'd12);
`ifdef RESULT_SIG_STALL_CNT_EN
            check($sformatf("vec%0d_stall", v), 64'(stall_a), 64'(vecs[v].stall));
`endif
        end

        // Scenario 4: restart mid-run.
        expected = 64'h2;
        pulse_start_a();
        run_samples(11, 64'h1, 1'b0);
        check("s4_mid_sig", sig_a, 64'd1);
        pulse_start_a();
        check("s4_restart_cnt", 64'(cnt_a), 64'd0);
        check("s4_restart_sig", sig_a, 64'd0);
        run_samples(12, 64'h1, 1'b0);
        check("s4_sig", sig_a, 64'h2);
        check("s4_pass", {62'd0, pass_a, fail_a}, 64'b10);

        // Scenario 5: asynchronous reset mid-ACCUM.
        pulse_start_a();
        run_samples(11, 64'h1, 1'b0);
        #3;
        reset_l = 1'b0;
        #1;
        check("s5_async_flags", {60'd0, busy_a, done_a, pass_a, fail_a}, 64'd0);
        check("s5_async_sig", sig_a, 64'd0);
        check("s5_async_cnt", 64'(cnt_a), 64'd0);
        #3;
        reset_l = 1'b1;
        run_samples(4, 64'h1, 1'b0);
        check("s5_post_cnt", 64'(cnt_a), 64'd0);
        check("s5_post_busy", {63'd0, busy_a}, 64'd0);

        // Scenario 6: default parameters, DONE hold.
        expected = 64'h0;
        start_b  = 1'b1;
        tick();
        start_b  = 1'b0;
        run_samples(99, 64'h0, 1'b0);
        check("s6_pass", {61'd0, done_b, pass_b, fail_b}, 64'b110);
        check("s6_cnt", 64'(cnt_b), 64'd99);
        run_samples(20, 64'h1234_5678_9ABC_DEF0, 1'b0);
        check("s6_hold_sig", sig_b, 64'd0);
        check("s6_hold_cnt", 64'(cnt_b), 64'd99);
        check("s6_hold_pass", {61'd0, done_b, pass_b, fail_b}, 64'b110);
`ifdef RESULT_SIG_STALL_CNT_EN
        check("s6_stall", 64'(stall_b), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_signature_checker.md
Name: result_signature_checker

Overview:
- Downstream stage of the device-under-test in the regression harness.
- Consumes the DUT's aggregated result vector each valid cycle and discards a settle window of samples.
- Folds the remaining samples into a MISR-style signature, then compares it against an expected constant and raises pass/fail.
- Replaces the hand-written sum/compare logic in test top modules with one reusable checker.

Parameters:
WIDTH, 64, result and signature width; must be at least 4.
SETTLE_CYC, 10, number of leading accepted samples that are discarded (signature held at 0).
TOTAL_CYC, 99, total accepted samples per run, including the settle samples; must be greater than SETTLE_CYC.

Ports:
clk  input  1  clock; all state updates on posedge.
reset_l  input  1  asynchronous active-low reset.
start  input  1  single-cycle pulse; clears the checker and begins a run.
in_valid  input  1  in_data carries a sample this cycle; the checker always accepts it, so there is no ready.
in_data  input  WIDTH  result vector from the DUT.
expected  input  WIDTH  golden signature; sampled on entry to DONE.
busy  output  1  high in SETTLE or ACCUM.
done  output  1  high in DONE.
pass  output  1  done and signature equals the sampled expected value.
fail  output  1  done and signature differs from the sampled expected value.
signature  output  WIDTH  current signature register.
sample_cnt  output  32  number of samples accepted in the current run.

Behaviour:
- Reset (reset_l low, asynchronous):
  - state = IDLE.
  - signature = 0, sample_cnt = 0, expected register = 0.
  - busy = done = pass = fail = 0.
- States: IDLE, SETTLE, ACCUM, DONE.
- start in any state:
  - Next state is SETTLE; signature and sample_cnt clear to 0.
  - A sample presented in the same cycle as start is ignored.
  - start has priority over every other event.
- An accepted sample is in_valid = 1 while in SETTLE or ACCUM with start low.
  - Each accepted sample increments sample_cnt.
  - Cycles with in_valid low leave all state unchanged; gaps do not alter the result.
- SETTLE:
  - signature is held at 0.
  - On the accepted sample that makes sample_cnt equal SETTLE_CYC, go to ACCUM.
- ACCUM, on each accepted sample:
  - fb = sig[WIDTH-1] ^ sig[2] ^ sig[0].
  - signature <= in_data ^ {sig[WIDTH-2:0], fb}.
  - On the accepted sample that makes sample_cnt equal TOTAL_CYC, that sample is folded in, then go to DONE. The expected register captures `expected` in the same cycle.
- DONE:
  - done = 1; pass/fail are decoded combinationally from signature vs the expected register, exactly one of them high.
  - done therefore rises one cycle after the final accepted sample.
  - State holds and in_valid is ignored until start or reset.
- IDLE: in_valid is ignored; all outputs hold their reset values.
- Reset mid-run aborts immediately; no partial pass/fail is produced.
- sample_cnt saturates at 32'hFFFFFFFF; this is unreachable when TOTAL_CYC is in range.

Optional Feature:
RESULT_SIG_STALL_CNT_EN
- When defined:
  - Adds output stall_cnt [31:0], which counts cycles in ACCUM with in_valid low and start low.
  - stall_cnt clears on reset and on start, and holds in DONE.
  - The run still completes normally.
- When undefined:
  - The port and its counter are absent.
  - All other behaviour is identical.

Test Plan:
1. Settle gating. WIDTH=64, SETTLE_CYC=10, TOTAL_CYC=12; start, then 12 consecutive samples with in_data=1 and expected=64'h2.
   - signature stays 0 through sample 10 and reads 1 after sample 11.
   - done and pass assert one cycle after sample 12 with signature=64'h2; fail stays 0.
2. Mismatch. Same stimulus as scenario 1 with expected=64'h3.
   - fail=1, pass=0, signature=64'h2.
3. Valid gaps. Same stimulus as scenario 1 with in_valid low on every other cycle.
   - Identical result: signature=64'h2 and pass.
   - With RESULT_SIG_STALL_CNT_EN defined, stall_cnt=2 (the two gap cycles falling between the ACCUM samples).
4. Restart mid-run. Pulse start after 11 accepted samples, then run 12 samples with in_data=1.
   - sample_cnt returns to 0 on the restart.
   - The final signature is 64'h2 and the result is pass.
5. Asynchronous reset. Drop reset_l mid-ACCUM, between clock edges.
   - All outputs read 0 immediately.
   - After release, in_valid is ignored until start.
6. DONE hold. Default parameters, in_data=0, expected=0, 99 samples.
   - pass=1.
   - 20 further valid cycles leave signature=0, sample_cnt=99 and pass=1.
